// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory, PC register and a
// circular fetch buffer that decouples fetch from the ID stage.
module if_fetch_unit #(
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      ADR_W      = 32,
    parameter int unsigned      IMEM_DEPTH = 1024,
    parameter int unsigned      BUF_DEPTH  = 4,
    parameter logic [ADR_W-1:0] RESET_PC   = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IMEM_WE,
    input  logic [$clog2(IMEM_DEPTH)-1:0]  IMEM_WADR,
    input  logic [DATA_W-1:0]              IMEM_WDATA,
    input  logic                           REDIRECT,
    input  logic [ADR_W-1:0]               REDIRECT_ADR,
    input  logic                           OUT_READY,
    output logic                           OUT_VALID,
    output logic [DATA_W-1:0]              CUR_INS_OUT,
    output logic [ADR_W-1:0]               NEXT_INS_ADR_OUT,
    output logic [$clog2(BUF_DEPTH):0]     BUF_COUNT
);

    localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [DATA_W-1:0] mem     [IMEM_DEPTH];
    logic [DATA_W-1:0] ins_buf [BUF_DEPTH];
    logic [ADR_W-1:0]  adr_buf [BUF_DEPTH];

    logic [ADR_W-1:0] pc;
    logic [ADR_W-1:0] pc_next;
    logic [IDX_W-1:0] idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [1:0]       unused_redirect_lsb;

    assign unused_redirect_lsb = REDIRECT_ADR[1:0];

    // Higher PC bits are ignored so fetch wraps modulo IMEM_DEPTH words.
    assign idx     = pc[IDX_W+1:2];
    assign pc_next = pc + ADR_W'(4);

    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        if (!REDIRECT) begin
            pop  = (count != '0) && OUT_READY;
            push = (count < FULL) || pop;
        end
    end

    // Memory is not reset; a same-edge fetch of the written index sees the old word.
    always_ff @(posedge CLK) begin
        if (IMEM_WE) begin
            mem[IMEM_WADR] <= IMEM_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            ins_buf[wr_ptr] <= mem[idx];
            adr_buf[wr_ptr] <= pc_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (REDIRECT) begin
            pc     <= {REDIRECT_ADR[ADR_W-1:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc_next;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign OUT_VALID        = (count != '0);
    assign CUR_INS_OUT      = ins_buf[rd_ptr];
    assign NEXT_INS_ADR_OUT = adr_buf[rd_ptr];
    assign BUF_COUNT        = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table of per-edge vectors plus
// hand sequences for wrap, write/fetch collision and asynchronous reset.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_WE = 1'b0;
    logic [3:0]  IMEM_WADR = '0;
    logic [31:0] IMEM_WDATA = '0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_ADR = '0;
    logic        OUT_READY = 1'b0;
    logic        OUT_VALID;
    logic [31:0] CUR_INS_OUT;
    logic [31:0] NEXT_INS_ADR_OUT;
    logic [2:0]  BUF_COUNT;

    if_fetch_unit #(
        .DATA_W(32), .ADR_W(32), .IMEM_DEPTH(DEPTH), .BUF_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK), .RST(RST), .IMEM_WE(IMEM_WE), .IMEM_WADR(IMEM_WADR),
        .IMEM_WDATA(IMEM_WDATA), .REDIRECT(REDIRECT), .REDIRECT_ADR(REDIRECT_ADR),
        .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .CUR_INS_OUT(CUR_INS_OUT),
        .NEXT_INS_ADR_OUT(NEXT_INS_ADR_OUT), .BUF_COUNT(BUF_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] radr;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_ins;
        logic [31:0] exp_adr;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] adr;
    } entry_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] tbmem [DEPTH];
    entry_t      sb [$];
    vec_t        vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic r, input logic d, input logic [31:0] ra,
                           input logic v, input logic [2:0] c, input logic [31:0] ins,
                           input logic [31:0] adr);
        vecs[i] = '{r, d, ra, v, c, ins, adr};
    endtask

    initial begin
        entry_t      e;
        entry_t      got;
        logic        prev_stall;
        logic [31:0] prev_ins;
        logic [31:0] prev_adr;
        int          pops;

        // Reset with ready=0 fills to 4, drains in order, then redirect to 0x13.
        set_vec(0, 0, 0, 0, 1, 1, 32'h100, 32'h4);
        set_vec(1, 0, 0, 0, 1, 2, 32'h100, 32'h4);
        set_vec(2, 0, 0, 0, 1, 3, 32'h100, 32'h4);
        for (int i = 3; i < 10; i++) set_vec(i, 0, 0, 0, 1, 4, 32'h100, 32'h4);
        set_vec(10, 1, 0, 0, 1, 4, 32'h101, 32'h8);
        set_vec(11, 1, 0, 0, 1, 4, 32'h102, 32'hC);
        set_vec(12, 1, 0, 0, 1, 4, 32'h103, 32'h10);
        set_vec(13, 1, 0, 0, 1, 4, 32'h104, 32'h14);
        set_vec(14, 0, 1, 32'h13, 0, 0, 32'h0, 32'h0);
        set_vec(15, 0, 0, 0, 1, 1, 32'h104, 32'h14);
        set_vec(16, 1, 0, 0, 1, 1, 32'h105, 32'h18);
        set_vec(17, 1, 0, 0, 1, 1, 32'h106, 32'h1C);

        for (int i = 0; i < DEPTH; i++) tbmem[i] = 32'h100 + i;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            IMEM_WE = 1'b1; IMEM_WADR = 4'(i); IMEM_WDATA = tbmem[i];
        end
        @(negedge CLK);
        IMEM_WE = 1'b0;
        check("reset_valid", 64'(OUT_VALID), 64'd0);
        check("reset_count", 64'(BUF_COUNT), 64'd0);

        RST = 1'b0;
        for (int i = 0; i < 18; i++) begin
            OUT_READY = vecs[i].ready; REDIRECT = vecs[i].redir; REDIRECT_ADR = vecs[i].radr;
            @(posedge CLK); #1;
            check($sformatf("vec%0d_valid", i), 64'(OUT_VALID), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 64'(BUF_COUNT), 64'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_ins", i), 64'(CUR_INS_OUT), 64'(vecs[i].exp_ins));
                check($sformatf("vec%0d_adr", i), 64'(NEXT_INS_ADR_OUT), 64'(vecs[i].exp_adr));
            end
            @(negedge CLK);
        end

        // Wrap from the last memory word back to index 0 under a stalling consumer.
        OUT_READY = 1'b0; REDIRECT = 1'b1; REDIRECT_ADR = 32'h3C;
        for (int k = 0; k < 60; k++) begin
            e.ins = tbmem[(15 + k) % DEPTH];
            e.adr = 32'h3C + 32'(4 * (k + 1));
            sb.push_back(e);
        end
        @(posedge CLK);
        @(negedge CLK);
        REDIRECT = 1'b0;
        prev_stall = 1'b0; prev_ins = '0; prev_adr = '0; pops = 0;
        for (int i = 0; i < 45; i++) begin
            OUT_READY = (i % 3) != 0;
            #1;
            check("valid_vs_count", 64'(OUT_VALID), 64'(BUF_COUNT != 0));
            if (prev_stall && OUT_VALID) begin
                check("stall_ins", 64'(CUR_INS_OUT), 64'(prev_ins));
                check("stall_adr", 64'(NEXT_INS_ADR_OUT), 64'(prev_adr));
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    got = sb.pop_front();
                    check("wrap_ins", 64'(CUR_INS_OUT), 64'(got.ins));
                    check("wrap_adr", 64'(NEXT_INS_ADR_OUT), 64'(got.adr));
                    pops++;
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_ins   = CUR_INS_OUT;
            prev_adr   = NEXT_INS_ADR_OUT;
            @(negedge CLK);
        end
        check("wrap_pops_enough", 64'(pops >= 20), 64'd1);

        // Write to index 2 on the same edge that fetches index 2.
        OUT_READY = 1'b0; REDIRECT = 1'b1; REDIRECT_ADR = 32'h8;
        @(negedge CLK);
        REDIRECT = 1'b0; IMEM_WE = 1'b1; IMEM_WADR = 4'd2; IMEM_WDATA = 32'hDEAD;
        @(posedge CLK); #1;
        check("collide_count", 64'(BUF_COUNT), 64'd1);
        check("collide_old_ins", 64'(CUR_INS_OUT), 64'h102);
        check("collide_adr", 64'(NEXT_INS_ADR_OUT), 64'hC);
        @(negedge CLK);
        IMEM_WE = 1'b0; tbmem[2] = 32'hDEAD;
        REDIRECT = 1'b1; REDIRECT_ADR = 32'h8;
        @(negedge CLK);
        REDIRECT = 1'b0;
        @(posedge CLK); #1;
        check("refetch_ins", 64'(CUR_INS_OUT), 64'(tbmem[2]));
        check("refetch_adr", 64'(NEXT_INS_ADR_OUT), 64'hC);

        // Asynchronous reset pulse between edges with three entries buffered.
        @(negedge CLK);
        REDIRECT = 1'b1; REDIRECT_ADR = 32'h0;
        @(negedge CLK);
        REDIRECT = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("pre_reset_count", 64'(BUF_COUNT), 64'd3);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("async_reset_valid", 64'(OUT_VALID), 64'd0);
        check("async_reset_count", 64'(BUF_COUNT), 64'd0);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("post_reset_count", 64'(BUF_COUNT), 64'd1);
        check("post_reset_ins", 64'(CUR_INS_OUT), 64'(tbmem[0]));
        check("post_reset_adr", 64'(NEXT_INS_ADR_OUT), 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL provide parameter ADR_W, default 32, byte-address width of PC.
REQ-003 SHALL provide parameter IMEM_DEPTH, default 1024, instruction words; power of 2, >=2.
REQ-004 SHALL provide parameter BUF_DEPTH, default 4, fetch-buffer entries; power of 2, >=2.
REQ-005 SHALL provide parameter RESET_PC, default 0, PC value after reset.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-008 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-009 SHALL have port IMEM_WE  input  1  instruction-memory load strobe.
REQ-010 SHALL have port IMEM_WADR  input  $clog2(IMEM_DEPTH)  word index to load.
REQ-011 SHALL have port IMEM_WDATA  input  DATA_W  word to load.
REQ-012 SHALL have port REDIRECT  input  1  branch/jump taken; flush and reload PC.
REQ-013 SHALL have port REDIRECT_ADR  input  ADR_W  redirect target byte address.
REQ-014 SHALL have port OUT_READY  input  1  ID stage accepts head entry.
REQ-015 SHALL have port OUT_VALID  output  1  head entry valid.
REQ-016 SHALL have port CUR_INS_OUT  output  DATA_W  head instruction.
REQ-017 SHALL have port NEXT_INS_ADR_OUT  output  ADR_W  head entry's PC+4.
REQ-018 SHALL have port BUF_COUNT  output  $clog2(BUF_DEPTH)+1  occupied entries.

Function
REQ-019 SHALL hold PC register; memory index = PC[$clog2(IMEM_DEPTH)+1:2]; higher PC bits ignored (wrap modulo IMEM_DEPTH words).
REQ-020 SHALL read instruction memory combinationally at current PC; memory contents not reset.
REQ-021 SHALL write IMEM_WDATA to IMEM_WADR on edge when IMEM_WE=1; same-edge fetch of same index captures old word.
REQ-022 Push condition: REDIRECT=0 and (BUF_COUNT<BUF_DEPTH or pop this edge).
REQ-023 On push SHALL enqueue {mem[index], PC+4} and set PC<=PC+4 (mod 2^ADR_W, wraps to 0).
REQ-024 Pop condition: OUT_VALID=1, OUT_READY=1, REDIRECT=0; head removed on that edge.
REQ-025 Simultaneous push and pop SHALL leave BUF_COUNT unchanged, including when full.
REQ-026 OUT_VALID SHALL equal (BUF_COUNT!=0); CUR_INS_OUT/NEXT_INS_ADR_OUT driven from head, don't-care when empty.
REQ-027 Head SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-028 On REDIRECT=1 edge: buffer emptied (BUF_COUNT<=0), no push/pop, PC<={REDIRECT_ADR[ADR_W-1:2],2'b00}.
REQ-029 After redirect, first target instruction SHALL be valid at head one edge later (redirect latency 2 edges).
REQ-030 Buffer SHALL be circular with read/write pointers wrapping at BUF_DEPTH; order strictly FIFO.
REQ-031 Fetch latency: instruction at PC visible at head one edge after push when buffer empty.

Reset
REQ-032 RST=1 SHALL asynchronously set PC=RESET_PC, pointers=0, BUF_COUNT=0, OUT_VALID=0.
REQ-033 RST asserted mid-operation SHALL discard buffer contents and any same-cycle push/pop/redirect.
REQ-034 First push SHALL occur on first rising edge with RST=0.

Verification
REQ-035 Load mem[0..7]=0x100..0x107, reset, OUT_READY=1 -> after edge 1 head=0x100/ADR 4; edge n head=0x100+n-1, ADR 4n.
REQ-036 OUT_READY=0 for 10 cycles (BUF_DEPTH=4) -> BUF_COUNT saturates at 4, PC=16, head stays 0x100; OUT_READY=1 -> 0x101,0x102... no gaps.
REQ-037 Full buffer, REDIRECT=1 ADR=0x13 -> next edge BUF_COUNT=0, OUT_VALID=0, PC=0x10; edge after: head=mem[4], ADR 0x14.
REQ-038 PC=4*(IMEM_DEPTH-1) -> fetches mem[IMEM_DEPTH-1] then mem[0] (PC=4*IMEM_DEPTH) without error.
REQ-039 IMEM_WE to index 2 with 0xDEAD on edge fetching index 2 -> buffered entry holds old word; later refetch via redirect returns 0xDEAD.
REQ-040 RST pulsed between edges with BUF_COUNT=3 -> outputs immediately OUT_VALID=0, BUF_COUNT=0; after release head=mem[RESET_PC/4].
